// File: rtl/key_event_decoder.sv
// key_event_decoder: turns debounced key edges into short-click, long-press and double-click pulses.
// Optional feature macro KEY_REPEAT_EN adds an auto-repeat pulse while the key stays long-held.
module key_event_decoder #(
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned DBL_CYC    = 15_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic short_pulse,
    output logic long_pulse,
    output logic dbl_pulse,
    output logic rep_pulse,
    output logic busy
);

    localparam int unsigned MAX_LD  = (LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC;
    localparam int unsigned MAX_CYC = (MAX_LD > REPEAT_CYC) ? MAX_LD : REPEAT_CYC;
    localparam int          CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_WAIT_DBL,
        S_PRESSED2,
        S_LONG_HELD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_q, dbl_d;
    logic             busy_q, busy_d;
    logic             press_ev;
    logic             release_ev;
`ifdef KEY_REPEAT_EN
    logic             rep_q, rep_d;
`endif

    assign press_ev   = key_flag & ~key_state;
    assign release_ev = key_flag &  key_state;

    always_comb begin
        state_d = state_q;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
        cnt_d   = cnt_inc;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_d   = 1'b0;
`endif

        // Where an input event and a timeout coincide, the key event takes priority.
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (press_ev) begin
                    state_d = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (release_ev) begin
                    state_d = S_WAIT_DBL;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = S_LONG_HELD;
                    long_d  = 1'b1;
                end
            end
            S_WAIT_DBL: begin
                if (press_ev) begin
                    state_d = S_PRESSED2;
                end else if (cnt_q == DBL_LAST) begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                end
            end
            S_PRESSED2: begin
                if (release_ev) begin
                    state_d = S_IDLE;
                    dbl_d   = 1'b1;
                end
            end
            S_LONG_HELD: begin
                if (release_ev) begin
                    state_d = S_IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (cnt_q == REP_LAST) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            busy_q  <= busy_d;
`ifdef KEY_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign dbl_pulse   = dbl_q;
    assign busy        = busy_q;
`ifdef KEY_REPEAT_EN
    assign rep_pulse   = rep_q;
`else
    assign rep_pulse   = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Testbench for key_event_decoder: directed gestures plus randomized key traffic,
// compared every cycle against a deadline-driven gesture model.
module tb_key_event_decoder;

   localparam int LongCyc   = 100;
   localparam int DblCyc    = 40;
   localparam int RepeatCyc = 20;

   localparam int ModeIdle  = 0;
   localparam int ModeDown  = 1;
   localparam int ModeGap   = 2;
   localparam int ModeDown2 = 3;
   localparam int ModeHeld  = 4;

   logic clk      = 1'b0;
   logic rst      = 1'b0;
   logic keyFlag  = 1'b0;
   logic keyState = 1'b1;
   logic shortPulse;
   logic longPulse;
   logic dblPulse;
   logic repPulse;
   logic busy;

   // Gesture model state: current phase and the edge number at which its timeout fires
   int mode     = ModeIdle;
   int deadline = 0;
`ifdef KEY_REPEAT_EN
   int repAt    = 0;
`endif
   logic expShort = 1'b0;
   logic expLong  = 1'b0;
   logic expDbl   = 1'b0;
   logic expRep   = 1'b0;
   logic expBusy  = 1'b0;

   int edgeNum    = 0;
   int errorCount = 0;
   int checkCount = 0;
   int shortCount = 0;
   int longCount  = 0;
   int dblCount   = 0;
   int repCount   = 0;
   int busyCount  = 0;

   logic [3:0] prevPulses = 4'b0000;

   always #5 clk = ~clk;

   key_event_decoder #(
      .LONG_CYC   (LongCyc),
      .DBL_CYC    (DblCyc),
      .REPEAT_CYC (RepeatCyc)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_flag    (keyFlag),
      .key_state   (keyState),
      .short_pulse (shortPulse),
      .long_pulse  (longPulse),
      .dbl_pulse   (dblPulse),
      .rep_pulse   (repPulse),
      .busy        (busy)
   );

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, edgeNum);
      end
   endtask

   // Pulses must never overlap and never last longer than one cycle
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("mon_onehot", 32'($countones({shortPulse, longPulse, dblPulse, repPulse}) <= 1), 32'd1);
         checkOutput("mon_width", 32'(prevPulses & {shortPulse, longPulse, dblPulse, repPulse}), 32'd0);
         prevPulses = {shortPulse, longPulse, dblPulse, repPulse};
      end else begin
         prevPulses = 4'b0000;
      end
   end

   task automatic modelReset();
      mode     = ModeIdle;
      deadline = 0;
      expShort = 1'b0;
      expLong  = 1'b0;
      expDbl   = 1'b0;
      expRep   = 1'b0;
      expBusy  = 1'b0;
   endtask

   // Advance the gesture model by one clock edge using the inputs sampled at that edge
   task automatic modelStep(input logic flag, input logic level);
      logic press;
      logic release_;
      press    = flag && !level;
      release_ = flag && level;
      expShort = 1'b0;
      expLong  = 1'b0;
      expDbl   = 1'b0;
      expRep   = 1'b0;
      case (mode)
         ModeIdle: begin
            if (press) begin
               mode     = ModeDown;
               deadline = edgeNum + LongCyc;
            end
         end
         ModeDown: begin
            if (release_) begin
               mode     = ModeGap;
               deadline = edgeNum + DblCyc;
            end else if (edgeNum == deadline) begin
               expLong = 1'b1;
               mode    = ModeHeld;
`ifdef KEY_REPEAT_EN
               repAt   = edgeNum + RepeatCyc;
`endif
            end
         end
         ModeGap: begin
            if (press) begin
               mode = ModeDown2;
            end else if (edgeNum == deadline) begin
               expShort = 1'b1;
               mode     = ModeIdle;
            end
         end
         ModeDown2: begin
            if (release_) begin
               expDbl = 1'b1;
               mode   = ModeIdle;
            end
         end
         default: begin
            if (release_) begin
               mode = ModeIdle;
            end
`ifdef KEY_REPEAT_EN
            else if (edgeNum == repAt) begin
               expRep = 1'b1;
               repAt  = repAt + RepeatCyc;
            end
`endif
         end
      endcase
      expBusy = (mode != ModeIdle);
   endtask

   // Drive one cycle of inputs (called #1 after an edge), then compare outputs after the next edge
   task automatic applyStimulus(input logic flag, input logic level);
      keyFlag  = flag;
      keyState = level;
      @(posedge clk);
      edgeNum++;
      #1;
      keyFlag = 1'b0;
      modelStep(flag, level);
      checkOutput("short", 32'(shortPulse), 32'(expShort));
      checkOutput("long", 32'(longPulse), 32'(expLong));
      checkOutput("dbl", 32'(dblPulse), 32'(expDbl));
      checkOutput("rep", 32'(repPulse), 32'(expRep));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      shortCount += int'(shortPulse);
      longCount  += int'(longPulse);
      dblCount   += int'(dblPulse);
      repCount   += int'(repPulse);
      busyCount  += int'(busy);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic clearTally();
      shortCount = 0;
      longCount  = 0;
      dblCount   = 0;
      repCount   = 0;
      busyCount  = 0;
   endtask

   // Asynchronous reset mid-cycle: outputs must clear before any clock edge
   task automatic doReset();
      rst = 1'b0;
      #1;
      checkOutput("rst_async_short", 32'(shortPulse), 32'd0);
      checkOutput("rst_async_long", 32'(longPulse), 32'd0);
      checkOutput("rst_async_dbl", 32'(dblPulse), 32'd0);
      checkOutput("rst_async_rep", 32'(repPulse), 32'd0);
      checkOutput("rst_async_busy", 32'(busy), 32'd0);
      modelReset();
      keyFlag  = 1'b1;
      keyState = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         edgeNum++;
         #1;
         checkOutput("rst_hold_pulses", 32'({shortPulse, longPulse, dblPulse, repPulse}), 32'd0);
         checkOutput("rst_hold_busy", 32'(busy), 32'd0);
      end
      keyFlag  = 1'b0;
      keyState = 1'b1;
      rst      = 1'b1;
   endtask

   initial begin
      #2;
      checkOutput("init_short", 32'(shortPulse), 32'd0);
      checkOutput("init_long", 32'(longPulse), 32'd0);
      checkOutput("init_dbl", 32'(dblPulse), 32'd0);
      checkOutput("init_rep", 32'(repPulse), 32'd0);
      checkOutput("init_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      modelReset();

      // Release with no preceding press
      clearTally();
      applyStimulus(1'b1, 1'b1);
      idleCycles(5);
      checkOutput("stray_pulses", 32'(shortCount + longCount + dblCount + repCount), 32'd0);
      checkOutput("stray_busy", 32'(busyCount), 32'd0);

      // Short click: release after 30 cycles
      clearTally();
      applyStimulus(1'b1, 1'b0);
      idleCycles(29);
      applyStimulus(1'b1, 1'b1);
      idleCycles(50);
      checkOutput("short_count", 32'(shortCount), 32'd1);
      checkOutput("short_busy_cycles", 32'(busyCount), 32'd70);
      checkOutput("short_others", 32'(longCount + dblCount + repCount), 32'd0);

      // Long hold of 150 cycles
      clearTally();
      applyStimulus(1'b1, 1'b0);
      idleCycles(149);
      applyStimulus(1'b1, 1'b1);
      idleCycles(60);
      checkOutput("long_count", 32'(longCount), 32'd1);
      checkOutput("long_others", 32'(shortCount + dblCount), 32'd0);
`ifdef KEY_REPEAT_EN
      checkOutput("long_rep_count", 32'(repCount), 32'd2);
`else
      checkOutput("long_rep_count", 32'(repCount), 32'd0);
`endif

      // Double click with a 200-cycle second hold
      clearTally();
      applyStimulus(1'b1, 1'b0);
      idleCycles(9);
      applyStimulus(1'b1, 1'b1);
      idleCycles(14);
      applyStimulus(1'b1, 1'b0);
      idleCycles(199);
      applyStimulus(1'b1, 1'b1);
      idleCycles(50);
      checkOutput("dbl_count", 32'(dblCount), 32'd1);
      checkOutput("dbl_others", 32'(shortCount + longCount), 32'd0);

      // Release in the same cycle the hold reaches its limit
      clearTally();
      applyStimulus(1'b1, 1'b0);
      idleCycles(99);
      applyStimulus(1'b1, 1'b1);
      idleCycles(50);
      checkOutput("edge_long_count", 32'(longCount), 32'd0);
      checkOutput("edge_long_short", 32'(shortCount), 32'd1);

      // One cycle later the long press wins
      clearTally();
      applyStimulus(1'b1, 1'b0);
      idleCycles(100);
      applyStimulus(1'b1, 1'b1);
      idleCycles(50);
      checkOutput("past_long_count", 32'(longCount), 32'd1);
      checkOutput("past_long_short", 32'(shortCount), 32'd0);

      // Second press in the same cycle the gap times out
      clearTally();
      applyStimulus(1'b1, 1'b0);
      idleCycles(5);
      applyStimulus(1'b1, 1'b1);
      idleCycles(39);
      applyStimulus(1'b1, 1'b0);
      idleCycles(3);
      applyStimulus(1'b1, 1'b1);
      idleCycles(50);
      checkOutput("edge_gap_dbl", 32'(dblCount), 32'd1);
      checkOutput("edge_gap_short", 32'(shortCount), 32'd0);

      // One cycle later the short click is already confirmed
      clearTally();
      applyStimulus(1'b1, 1'b0);
      idleCycles(5);
      applyStimulus(1'b1, 1'b1);
      idleCycles(40);
      applyStimulus(1'b1, 1'b0);
      idleCycles(3);
      applyStimulus(1'b1, 1'b1);
      idleCycles(50);
      checkOutput("past_gap_short", 32'(shortCount), 32'd2);
      checkOutput("past_gap_dbl", 32'(dblCount), 32'd0);

      // Reset while pressed, then while waiting for a second click
      clearTally();
      applyStimulus(1'b1, 1'b0);
      idleCycles(20);
      doReset();
      idleCycles(150);
      applyStimulus(1'b1, 1'b0);
      idleCycles(5);
      applyStimulus(1'b1, 1'b1);
      idleCycles(10);
      doReset();
      applyStimulus(1'b1, 1'b1);
      idleCycles(60);
      checkOutput("reset_pulses", 32'(shortCount + longCount + dblCount + repCount), 32'd0);

      // Randomized traffic: random quiet spans, random edges, occasional resets
      for (int seg = 0; seg < 300; seg++) begin
         idleCycles(int'($urandom_range(0, 130)));
         if ($urandom_range(0, 49) == 0) begin
            doReset();
         end else begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)));
         end
      end
      idleCycles(200);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter LONG_CYC, default 50_000_000, hold duration in clk cycles for a long press (1 s at 50 MHz).
REQ-002 Parameter DBL_CYC, default 15_000_000, maximum released gap in cycles for a second press to count as a double click.
REQ-003 Parameter REPEAT_CYC, default 10_000_000, auto-repeat period in cycles (KEY_REPEAT_EN only).
REQ-004 clk  input  1  system clock, 50 MHz; the single clock domain.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 key_flag  input  1  one-cycle pulse from the debounce stage marking a debounced edge.
REQ-007 key_state  input  1  debounced key level from the debounce stage: 0 = pressed, 1 = released.
REQ-008 short_pulse  output  1  one-cycle pulse: single short click confirmed.
REQ-009 long_pulse  output  1  one-cycle pulse: hold reached LONG_CYC.
REQ-010 dbl_pulse  output  1  one-cycle pulse: double click confirmed.
REQ-011 rep_pulse  output  1  one-cycle pulse: auto-repeat tick while long-held; tied 0 without KEY_REPEAT_EN.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 Press event = key_flag=1 and key_state=0; release event = key_flag=1 and key_state=1; key_state is otherwise ignored.
REQ-014 FSM states: IDLE, PRESSED, WAIT_DBL, PRESSED2, LONG_HELD; a single cycle counter cnt, width ceil(log2(max parameter))+1, cleared on every state change.
REQ-015 IDLE: press -> PRESSED; release ignored.
REQ-016 PRESSED: cnt increments each cycle; release -> WAIT_DBL; cnt = LONG_CYC-1 without release -> LONG_HELD with long_pulse.
REQ-017 PRESSED: release in the same cycle cnt = LONG_CYC-1 -> release wins, WAIT_DBL, no long_pulse.
REQ-018 WAIT_DBL: cnt increments; press -> PRESSED2; cnt = DBL_CYC-1 without press -> IDLE with short_pulse.
REQ-019 WAIT_DBL: press in the same cycle as timeout -> press wins, PRESSED2, no short_pulse.
REQ-020 PRESSED2: release -> IDLE with dbl_pulse, regardless of hold length; no long detection in PRESSED2.
REQ-021 LONG_HELD: release -> IDLE with no further pulse; press ignored.
REQ-022 All outputs registered; each pulse asserts exactly one cycle, on the clock edge after the triggering input or counter condition.
REQ-023 At most one of short/long/dbl/rep_pulse high in any cycle.
REQ-024 Counter never wraps: it stops incrementing at its terminal value in every state.

Reset
REQ-025 rst=0 asynchronously forces state IDLE, cnt=0, all pulse outputs 0, busy 0.
REQ-026 Reset mid-gesture discards the gesture; no pulse is emitted on or after reset release until a new press occurs.
REQ-027 After rst rises, a release with no preceding press is ignored.

Configuration
REQ-028 Macro KEY_REPEAT_EN defined: in LONG_HELD, cnt restarts at long_pulse and rep_pulse fires every REPEAT_CYC cycles until release; the first rep_pulse comes REPEAT_CYC cycles after long_pulse.
REQ-029 KEY_REPEAT_EN undefined: repeat counter logic is absent, rep_pulse is constant 0, and all other behaviour is identical.

Verification (bench overrides LONG_CYC=100, DBL_CYC=40, REPEAT_CYC=20)
REQ-030 Press, release after 30 cycles, no further input -> exactly one short_pulse 40 cycles after release; busy high 70 cycles.
REQ-031 Press held 150 cycles -> long_pulse 100 cycles after press; no short_pulse or dbl_pulse; with KEY_REPEAT_EN, rep_pulse at press+120 and press+140, then nothing after release.
REQ-032 Press 10, release, press again 15 cycles later, release after 200 -> single dbl_pulse on second release; no long_pulse, no short_pulse.
REQ-033 Boundaries: release exactly at cnt=99 -> no long_pulse; second press exactly at gap cnt=39 -> dbl path, no short_pulse.
REQ-034 rst pulsed low while in PRESSED and while in WAIT_DBL -> outputs 0 immediately, no pulse afterwards; a stray release after reset -> no output.
REQ-035 Self-check: a monitor asserts one-hot-or-zero across the four pulses and single-cycle width of each, for the whole run.
